// File: rtl/cc_pkg.sv
// ---------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the lag streamer slice.
//   DATA_W    : default width of a signed correlation value
//   IDX_W     : default width of a lag index
//   MIN_VALUE : most negative DATA_W value; presented on value_out whenever
//               no frame element is being streamed
//   state_t   : streaming FSM states
// ---------------------------------------------------------------------------
package cc_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;

    localparam logic [DATA_W-1:0] MIN_VALUE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/lag_streamer_if.sv
// ---------------------------------------------------------------------------
// lag_streamer_if
// Bundles the write port, frame request and streamed-output signals of
// lag_streamer.
//   Producer side : wr_en, wr_addr, wr_data, frame_ready, overrun_clr
//   Stream side   : frame_start, value_out, index_out, value_valid,
//                   frame_done, busy, overrun
// Modports:
//   master : the environment (drives writes/requests, observes the stream)
//   slave  : the lag_streamer itself
// ---------------------------------------------------------------------------
interface lag_streamer_if #(
    parameter int DATA_W = cc_pkg::DATA_W,
    parameter int IDX_W  = cc_pkg::IDX_W
);

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_ready;
    logic              overrun_clr;

    logic              frame_start;
    logic [DATA_W-1:0] value_out;
    logic [IDX_W-1:0]  index_out;
    logic              value_valid;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    modport master (
        output wr_en, wr_addr, wr_data, frame_ready, overrun_clr,
        input  frame_start, value_out, index_out, value_valid,
               frame_done, busy, overrun
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, frame_ready, overrun_clr,
        output frame_start, value_out, index_out, value_valid,
               frame_done, busy, overrun
    );

endinterface

// File: rtl/lag_bank_ram.sv
// ---------------------------------------------------------------------------
// lag_bank_ram
// Simple dual-port synchronous RAM holding two banks of NUM_LAGS words.
// A location is selected by {bank, addr}: bank 1 occupies the upper
// NUM_LAGS words. Read data appears one clock after the read address.
// Contents are never reset.
// Ports:
//   clk        : clock, rising edge
//   wr_en_i    : write strobe
//   wr_bank_i  : bank of the write
//   wr_addr_i  : lag index of the write
//   wr_data_i  : write data
//   rd_bank_i  : bank of the read
//   rd_addr_i  : lag index of the read
//   rd_data_o  : registered read data
// ---------------------------------------------------------------------------
module lag_bank_ram #(
    parameter int NUM_LAGS = 256,
    parameter int DATA_W   = cc_pkg::DATA_W,
    parameter int IDX_W    = cc_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic              wr_bank_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_bank_i,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 * NUM_LAGS;
    localparam int AW    = $clog2(DEPTH);

    // With NUM_LAGS = 2^IDX_W the offset below is exactly the {bank, addr}
    // concatenation; the explicit offset keeps non-power-of-two frames packed.
    function automatic logic [AW-1:0] flat_addr(input logic bank,
                                                input logic [IDX_W-1:0] addr);
        logic [AW-1:0] base;
        base = bank ? AW'(NUM_LAGS) : '0;
        return base + AW'(addr);
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_flat;
    logic [AW-1:0]     rd_flat;

    assign wr_flat = flat_addr(wr_bank_i, wr_addr_i);
    assign rd_flat = flat_addr(rd_bank_i, rd_addr_i);

    // Write port and one-cycle registered read port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_flat] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_flat];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lag_streamer.sv
// ---------------------------------------------------------------------------
// lag_streamer
// Ping-pong buffered streamer for a frame of NUM_LAGS signed correlation
// values. Writes always fill the write bank; a frame_ready while idle swaps
// banks and streams the just-completed bank out, one element per cycle,
// framed by frame_start (one cycle before the first element) and
// frame_done (one cycle after the last). Requests arriving while busy are
// dropped and flagged on the sticky overrun output.
// NUM_LAGS is meaningful only in the range 2..2^IDX_W.
//
// Optional build macro:
//   LAG_STREAMER_WINDOW_EN : adds lag_lo/lag_hi; elements outside
//                            [lag_lo, lag_hi] are streamed as MIN_VALUE with
//                            unchanged timing and index.
//
// Ports:
//   clk      : clock, rising edge
//   reset_b  : asynchronous active-low reset
//   bus      : lag_streamer_if.slave (write port, request, stream outputs)
//   lag_lo   : (window build) lowest lag passed through, sampled at START
//   lag_hi   : (window build) highest lag passed through, sampled at START
// ---------------------------------------------------------------------------
module lag_streamer #(
    parameter int NUM_LAGS = 256,
    parameter int DATA_W   = cc_pkg::DATA_W,
    parameter int IDX_W    = cc_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             reset_b,
    lag_streamer_if.slave    bus
`ifdef LAG_STREAMER_WINDOW_EN
    ,
    input  logic [IDX_W-1:0] lag_lo,
    input  logic [IDX_W-1:0] lag_hi
`endif
);

    import cc_pkg::*;

    // Derived from the module's own DATA_W so non-default widths stay correct.
    localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LAGS - 1);

    state_t            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overrun_q, overrun_d;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              in_window;

    lag_bank_ram #(
        .NUM_LAGS (NUM_LAGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (bus.wr_en),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_bank_i (~wr_bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // State, bank pointer, element counter and sticky overrun flag.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic. The read address always runs one element ahead of
    // idx_q to cover the RAM's one-cycle read latency: START fetches
    // element 0, and each STREAM cycle fetches the element after the one
    // being presented. A write coinciding with an accepted request still
    // uses the old wr_bank_q, so it lands in the bank about to be streamed.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        idx_d     = idx_q;
        rd_addr   = '0;
        // A rejected request sets the flag even when a clear arrives with it.
        overrun_d = (bus.frame_ready && (state_q != IDLE)) ? 1'b1 :
                    (bus.overrun_clr ? 1'b0 : overrun_q);

        case (state_q)
            IDLE: begin
                if (bus.frame_ready) begin
                    state_d   = START;
                    wr_bank_d = ~wr_bank_q;
                end
            end
            START: begin
                rd_addr = '0;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                rd_addr = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef LAG_STREAMER_WINDOW_EN
    logic [IDX_W-1:0] lo_q, hi_q;

    // Window bounds are captured once per frame so the host may change
    // them while a frame is in flight.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lo_q <= '0;
            hi_q <= '0;
        end else if (state_q == START) begin
            lo_q <= lag_lo;
            hi_q <= lag_hi;
        end
    end

    assign in_window = (idx_q >= lo_q) && (idx_q <= hi_q);
`else
    assign in_window = 1'b1;
`endif

    // Outputs decode straight from registered state, so an asynchronous
    // reset returns them to their idle values immediately.
    assign bus.frame_start = (state_q == START);
    assign bus.value_valid = (state_q == STREAM);
    assign bus.frame_done  = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.index_out   = (state_q == STREAM) ? idx_q : '0;
    assign bus.value_out   = ((state_q == STREAM) && in_window) ? rd_data : MIN_VAL;

endmodule

// File: doc/lag_streamer.md
LAG_STREAMER -- requirements
Module: lag_streamer

Interface
REQ-001 Parameter NUM_LAGS, 256, lags per frame; SHALL be legal only for 2..2^IDX_W.
REQ-002 Parameter DATA_W, 32, signed correlation value width.
REQ-003 Parameter IDX_W, 8, lag index width.
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 reset_b  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  write strobe into the current write bank.
REQ-007 wr_addr  in  IDX_W  lag index of the write.
REQ-008 wr_data  in  DATA_W  signed correlation value.
REQ-009 frame_ready  in  1  one-cycle pulse: write bank complete; request to stream it.
REQ-010 overrun_clr  in  1  clears overrun.
REQ-011 frame_start  out  1  one-cycle pulse, one cycle before the first valid value; clears a downstream arg-max.
REQ-012 value_out  out  DATA_W  streamed value; SHALL be MIN_VALUE (0x8000_0000 at DATA_W=32) whenever value_valid=0.
REQ-013 index_out  out  IDX_W  lag index of value_out; SHALL be 0 when value_valid=0.
REQ-014 value_valid  out  1  value_out/index_out carry a frame element.
REQ-015 frame_done  out  1  one-cycle pulse, the cycle after the last valid value.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 overrun  out  1  sticky: a frame_ready was rejected.

Function
REQ-018 Storage SHALL be two banks of NUM_LAGS words (ping-pong). wr_* SHALL always target the write bank. Reads SHALL always target the other bank.
REQ-019 FSM states SHALL be IDLE, START, STREAM and DONE.
REQ-020 In IDLE, frame_ready at cycle T SHALL swap banks at the T edge and enter START. START occupies cycle T+1.
REQ-021 START SHALL assert frame_start and issue the read of address 0. Next state is STREAM.
REQ-022 In STREAM, element k SHALL appear with value_valid=1 at cycle T+2+k, for k=0..NUM_LAGS-1. Elements SHALL be contiguous with no gaps. index_out SHALL equal k.
REQ-023 After element NUM_LAGS-1, the FSM SHALL enter DONE for one cycle (T+2+NUM_LAGS). DONE asserts frame_done, then returns to IDLE.
REQ-024 A frame_ready while busy=1 (including the DONE cycle) SHALL be rejected. A rejected frame_ready SHALL NOT swap banks and SHALL set overrun on the next edge. The write bank keeps accepting writes.
REQ-025 A wr_en in the same cycle as an accepted frame_ready SHALL land in the pre-swap bank.
REQ-026 If overrun_clr and a rejection occur in the same cycle, set SHALL win.
REQ-027 The write address SHALL NOT be range-checked. Behaviour for wr_addr >= NUM_LAGS is undefined.
REQ-028 Values SHALL pass through unmodified. There SHALL be no arithmetic on data except the MIN_VALUE substitution.

Reset
REQ-029 On reset_b=0, the FSM SHALL go to IDLE and the write bank SHALL be bank 0.
REQ-030 On reset_b=0, frame_start, value_valid, frame_done, busy and overrun SHALL be 0.
REQ-031 On reset_b=0, value_out SHALL be MIN_VALUE and index_out SHALL be 0.
REQ-032 Reset mid-frame SHALL abort the stream immediately with no frame_done. RAM contents SHALL NOT be cleared.

Configuration
REQ-033 With LAG_STREAMER_WINDOW_EN defined, inputs lag_lo and lag_hi (IDX_W each, sampled at START) SHALL exist.
REQ-034 With LAG_STREAMER_WINDOW_EN defined, elements with index < lag_lo or index > lag_hi SHALL be streamed with value_out=MIN_VALUE. Their index_out, value_valid and timing SHALL be unchanged.
REQ-035 Without LAG_STREAMER_WINDOW_EN, those ports SHALL be absent and all values SHALL pass through.

Structure
REQ-036 Shared package cc_pkg SHALL hold DATA_W, IDX_W, MIN_VALUE and the FSM state type.
REQ-037 Storage SHALL be one sub-module, lag_bank_ram. It SHALL be a simple dual-port synchronous RAM with depth 2*NUM_LAGS, addressed {bank,addr}, with 1-cycle read latency.

Verification
REQ-038 Fill bank 0 with value[k]=k-128, pulse frame_ready at T -> frame_start at T+1; index 0..255 at T+2..T+257; frame_done at T+258; busy low at T+259.
REQ-039 Frame with a single peak 0x7FFF_0000 at lag 37, streamed into an arg-max consumer -> consumer reports index 37 at frame_done. Idle cycles present MIN_VALUE.
REQ-040 frame_ready during STREAM and again during DONE -> overrun=1, no bank swap, the current stream completes intact. overrun_clr -> overrun=0.
REQ-041 Write lag 5 while the other bank streams, then frame_ready -> the next stream shows the new lag-5 value. The in-flight stream shows the old value.
REQ-042 reset_b low at element 100 -> outputs take reset values asynchronously, no frame_done. A new frame_ready after release streams a full frame.
REQ-043 WINDOW_EN build with lag_lo=10, lag_hi=20 -> elements 0..9 and 21..255 are MIN_VALUE, elements 10..20 pass through unchanged, timing is identical to REQ-038.
